// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// special result codes and the capture-path state encoding.
package seg_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h3f;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5b;
    localparam logic [6:0] SEG_3     = 7'h4f;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6d;
    localparam logic [6:0] SEG_6     = 7'h7d;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7f;
    localparam logic [6:0] SEG_9     = 7'h6f;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        PUBLISH = 2'd3
    } state_e;

endpackage

// File: rtl/seg_scan_decoder_pattern.sv
// Combinational lookup from a 7-bit segment pattern (a..g) back to its BCD
// code; blank maps to CODE_BLANK, anything unrecognised to CODE_ERR with err set.
module seg_pattern_decoder
    import seg_scan_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    always_comb begin
        code_o = CODE_ERR;
        err_o  = 1'b1;
        case (pat_i)
            SEG_0:     begin code_o = 4'd0;       err_o = 1'b0; end
            SEG_1:     begin code_o = 4'd1;       err_o = 1'b0; end
            SEG_2:     begin code_o = 4'd2;       err_o = 1'b0; end
            SEG_3:     begin code_o = 4'd3;       err_o = 1'b0; end
            SEG_4:     begin code_o = 4'd4;       err_o = 1'b0; end
            SEG_5:     begin code_o = 4'd5;       err_o = 1'b0; end
            SEG_6:     begin code_o = 4'd6;       err_o = 1'b0; end
            SEG_7:     begin code_o = 4'd7;       err_o = 1'b0; end
            SEG_8:     begin code_o = 4'd8;       err_o = 1'b0; end
            SEG_9:     begin code_o = 4'd9;       err_o = 1'b0; end
            SEG_BLANK: begin code_o = CODE_BLANK; err_o = 1'b0; end
            default:   begin code_o = CODE_ERR;   err_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed seven-segment scan bus,
// debouncing each (select, pattern) pair and publishing whole frames atomically.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid
);

    localparam logic [7:0] DWELL = 8'(STABLE_CYC);

    logic [7:0]        seg_s1_q;
    logic [DIGITS-1:0] sel_s1_q;
    logic [7:0]        cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [DIGITS-1:0] seen_q;
    logic [3:0]        shd_code_q [DIGITS];
    logic [DIGITS-1:0] shd_dp_q, shd_err_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0] dp_q, err_q;
    logic              fv_q;

    logic [3:0] dec_code;
    logic       dec_err;
    logic       chg, clr, hit, full;
    logic       unused_spare;

    assign unused_spare = seg_in[8];

    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
    endfunction

    seg_pattern_decoder u_dec (
        .pat_i  (seg_s1_q[6:0]),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    // Compare against what s1 is about to load, so the count tracks how long s1 has held.
    assign chg  = (seg_in[7:0] != seg_s1_q) || (dig_sel != sel_s1_q);
    assign clr  = chg || !is_onehot(dig_sel);
    assign hit  = (cnt_d == DWELL) && (cnt_q != DWELL);
    assign full = &(seen_q | sel_s1_q);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (cnt_q >= DWELL)
            cnt_d = DWELL;
        else
            cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (hit) state_d = CAPTURE;
            CAPTURE: state_d = full ? PUBLISH : HOLD;
            // A short dwell can mature while publishing; don't drop it.
            PUBLISH: state_d = hit ? CAPTURE : (clr ? WAIT : HOLD);
            HOLD: begin
                if (hit)      state_d = CAPTURE;
                else if (clr) state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q  <= '0;
            sel_s1_q  <= '0;
            cnt_q     <= '0;
            state_q   <= WAIT;
            seen_q    <= '0;
            shd_dp_q  <= '0;
            shd_err_q <= '0;
            for (int i = 0; i < DIGITS; i++) shd_code_q[i] <= CODE_BLANK;
            bcd_q     <= '1;
            dp_q      <= '0;
            err_q     <= '0;
            fv_q      <= 1'b0;
        end else begin
            seg_s1_q <= seg_in[7:0];
            sel_s1_q <= dig_sel;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            fv_q     <= 1'b0;
            if (state_q == CAPTURE) begin
                seen_q <= seen_q | sel_s1_q;
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_s1_q[i]) begin
                        shd_code_q[i] <= dec_code;
                        shd_dp_q[i]   <= seg_s1_q[7];
                        shd_err_q[i]  <= dec_err;
                    end
                end
            end else if (state_q == PUBLISH) begin
                seen_q <= '0;
                for (int i = 0; i < DIGITS; i++) bcd_q[4*i +: 4] <= shd_code_q[i];
                dp_q   <= shd_dp_q;
                err_q  <= shd_err_q;
                fv_q   <= 1'b1;
            end
        end
    end

    assign bcd_out     = bcd_q;
    assign dp_out      = dp_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (DIGITS=4, STABLE_CYC=4).
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_cyc = -1;
    int p0, c0;

    seg_scan_decoder #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            pulses   <= pulses + 1;
            last_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a (select, pattern) pair for n cycles; entered and left at posedge+1.
    task automatic hold(input logic [3:0] sel, input logic [8:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hold(4'b0000, 9'h000, n);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;
        idle(20);
        chk("idle_pulses", 32'(pulses), 32'd0);

        // Clean frame with latency measurement on the last digit
        p0 = pulses;
        hold(4'b0001, 9'h006, 8);
        hold(4'b0010, 9'h05b, 8);
        hold(4'b0100, 9'h04f, 8);
        c0 = cyc;
        hold(4'b1000, 9'h166, 8);   // spare bit set: must be ignored
        idle(4);
        chk("clean_pulses", 32'(pulses - p0), 32'd1);
        chk("clean_bcd", 32'(bcd_out), 32'h4321);
        chk("clean_err", 32'(digit_err), 32'h0);
        chk("clean_dp", 32'(dp_out), 32'h0);
        chk("clean_latency", 32'(last_cyc - c0), 32'd7);
        chk("clean_fv_low", 32'(frame_valid), 32'h0);

        // Error, blank and decimal point
        p0 = pulses;
        hold(4'b0001, 9'h000, 8);
        hold(4'b0010, 9'h049, 8);
        hold(4'b0100, 9'h0bf, 8);
        hold(4'b1000, 9'h06f, 8);
        idle(4);
        chk("errblk_pulses", 32'(pulses - p0), 32'd1);
        chk("errblk_bcd", 32'(bcd_out), 32'h90EF);
        chk("errblk_err", 32'(digit_err), 32'h2);
        chk("errblk_dp", 32'(dp_out), 32'h4);

        // Glitch on digit 2 followed by the real pattern
        p0 = pulses;
        hold(4'b0001, 9'h006, 8);
        hold(4'b0010, 9'h05b, 8);
        hold(4'b0100, 9'h07f, 3);
        hold(4'b0100, 9'h04f, 8);
        hold(4'b1000, 9'h066, 8);
        idle(4);
        chk("glitch_pulses", 32'(pulses - p0), 32'd1);
        chk("glitch_bcd", 32'(bcd_out), 32'h4321);

        // A 3-cycle dwell alone must not mark digit 2 as seen
        p0 = pulses;
        hold(4'b0001, 9'h03f, 8);
        hold(4'b0010, 9'h07d, 8);
        hold(4'b0100, 9'h07f, 3);
        idle(6);
        hold(4'b1000, 9'h007, 8);
        idle(6);
        chk("short_nopulse", 32'(pulses - p0), 32'd0);
        chk("short_hold_bcd", 32'(bcd_out), 32'h4321);
        hold(4'b0100, 9'h06d, 8);
        idle(4);
        chk("short_pulses", 32'(pulses - p0), 32'd1);
        chk("short_bcd", 32'(bcd_out), 32'h7560);

        // Overlapping then empty select: nothing captured
        p0 = pulses;
        hold(4'b0011, 9'h006, 10);
        hold(4'b0000, 9'h05b, 10);
        hold(4'b0100, 9'h04f, 8);
        hold(4'b1000, 9'h066, 8);
        idle(6);
        chk("ovl_nopulse", 32'(pulses - p0), 32'd0);
        chk("ovl_hold_bcd", 32'(bcd_out), 32'h7560);
        hold(4'b0001, 9'h006, 8);
        hold(4'b0010, 9'h05b, 8);
        idle(4);
        chk("ovl_pulses", 32'(pulses - p0), 32'd1);
        chk("ovl_bcd", 32'(bcd_out), 32'h4321);

        // Reset mid-frame discards partial shadow state
        hold(4'b0001, 9'h07d, 8);
        hold(4'b0010, 9'h007, 8);
        idle(2);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_bcd", 32'(bcd_out), 32'hFFFF);
        chk("mid_rst_dp", 32'(dp_out), 32'h0);
        chk("mid_rst_err", 32'(digit_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = pulses;
        hold(4'b0100, 9'h07f, 8);
        hold(4'b1000, 9'h06f, 8);
        idle(6);
        chk("mid_rst_nopulse", 32'(pulses - p0), 32'd0);
        chk("mid_rst_hold_bcd", 32'(bcd_out), 32'hFFFF);
        hold(4'b0001, 9'h03f, 8);
        hold(4'b0010, 9'h006, 8);
        idle(4);
        chk("mid_rst_pulses", 32'(pulses - p0), 32'd1);
        chk("mid_rst_bcd_new", 32'(bcd_out), 32'h9810);

        // Minimum dwell that still captures (STABLE_CYC+1 input cycles)
        p0 = pulses;
        hold(4'b0001, 9'h006, 5);
        hold(4'b0010, 9'h05b, 5);
        hold(4'b0100, 9'h04f, 5);
        hold(4'b1000, 9'h066, 5);
        idle(6);
        chk("min_dwell_pulses", 32'(pulses - p0), 32'd1);
        chk("min_dwell_bcd", 32'(bcd_out), 32'h4321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
